ext_interrupt_debouncer_multi: RTL and testbench
================================================

Name: ext_interrupt_debouncer_multi

Overview:
- Parametrised successor to the single-line 1 us interrupt debouncer.
- Synchronises and debounces CHANNELS independent external interrupt lines, for example from the accelerometer INT1/INT2 pins.
- Supports per-channel polarity inversion and independent assert and deassert qualification times.
- Generates registered level, edge-pulse and sticky-pending outputs; sits between the top-level pins and the sensor driver FSM.

Parameters:
CHANNELS, 2, number of independent interrupt lines (>=1)
SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)
T_ASSERT, 20, consecutive high samples required to assert the output (1 us at 20 MHz; >=1)
T_DEASSERT, 20, consecutive low samples required to deassert the output (>=1)
INVERT_MASK, 0 (CHANNELS bits), bit i set means channel i is active-low at the pin

Ports:
i_clk_20mhz  in  1  20 MHz system clock
i_rst_20mhz  in  1  reset, asynchronous assert, active-low
ei_interrupt  in  CHANNELS  raw external interrupt lines, asynchronous to the clock
i_ack  in  CHANNELS  clears the matching o_pending bit; sampled on rising clock edge
o_int_deb  out  CHANNELS  debounced, polarity-normalised level (1 = interrupt active); registered
o_int_rise  out  CHANNELS  one-cycle pulse in the cycle o_int_deb goes 0->1
o_int_fall  out  CHANNELS  one-cycle pulse in the cycle o_int_deb goes 1->0
o_pending  out  CHANNELS  sticky flag, set by rise, cleared by i_ack
o_any_pending  out  1  OR-reduction of o_pending; registered

Behaviour:
- Reset (i_rst_20mhz=0, asynchronous):
  - every output is 0;
  - every FSM is in IDLE with its timer at 0;
  - synchroniser flops of channel i load INVERT_MASK[i], so the normalised level is 0.
- Synchroniser: SYNC_STAGES-flop chain per channel. Normalised level n[i] = last stage XOR INVERT_MASK[i].
- Per-channel FSM with 2-bit state and Gray encoding; the default branch recovers to IDLE.
  - IDLE (deb=0): n=1 -> QUAL_HI, else stay.
  - QUAL_HI (deb=0): n=0 -> IDLE; after T_ASSERT consecutive n=1 samples -> ASSERTED.
  - ASSERTED (deb=1): n=0 -> QUAL_LO, else stay.
  - QUAL_LO (deb=1): n=1 -> ASSERTED; after T_DEASSERT consecutive n=0 samples -> IDLE.
- Timer per channel:
  - width = clog2(max(T_ASSERT,T_DEASSERT)+1);
  - cleared on every state change; increments while in QUAL_HI or QUAL_LO; saturates and never wraps.
- Qualification counting and glitch rejection:
  - The sample that causes entry to QUAL_HI counts as sample 1.
  - o_int_deb rises on the edge on which the T_ASSERT-th consecutive high sample is taken.
  - Pin-to-o_int_deb latency is SYNC_STAGES+T_ASSERT edges; deassert is symmetric with T_DEASSERT.
  - Pulses of fewer than T_ASSERT samples, or gaps of fewer than T_DEASSERT samples, produce no o_int_deb change.
- T_ASSERT=1: IDLE->ASSERTED directly on the first high sample; QUAL_HI is never occupied. T_DEASSERT=1 likewise.
- o_int_deb is registered from the FSM, never combinational from the inputs. The output must be glitch-free.
- o_int_rise/o_int_fall: registered pulses concurrent with the o_int_deb edge, exactly one cycle wide.
- o_pending[i]:
  - set when o_int_rise[i]=1 is generated;
  - cleared on the edge where i_ack[i]=1;
  - simultaneous set and ack: set wins, pending stays 1;
  - ack while pending=0 has no effect.
- o_any_pending: registered OR of the next-state o_pending vector, so it is cycle-aligned with o_pending.
- Channels are fully independent; no shared timer.
- Reset mid-qualification aborts the qualification; no pulse is emitted on reset.

Test Plan:
- Reset, T_ASSERT=20, ch0 pin held 1 -> o_int_deb[0]=0 for 21 edges after release sync; rises on edge 22 (2 sync + 20), with o_int_rise[0] high for exactly that cycle and o_pending[0]=1 on the next cycle.
- Glitch rejection: ch0 high for 19 cycles then low -> o_int_deb, o_int_rise and o_pending stay 0; a 20-cycle pulse asserts.
- Deassert bounce: while asserted, drive low for 10 cycles, high for 3, low for 25 -> o_int_deb stays 1 through the bounce. It falls 2+20 edges after the final low edge, and o_int_fall pulses once.
- Polarity: INVERT_MASK=2'b10, ch1 pin idles 1 -> o_int_deb[1]=0 with no pulse after reset; pin low for 20+ cycles -> o_int_deb[1]=1.
- Ack race: assert i_ack[0] in the same cycle a new o_int_rise[0] is generated -> o_pending[0] remains 1; a later ack clears it and o_any_pending drops one cycle after (both channels idle).
- Async reset asserted mid-QUAL_LO -> all outputs 0 immediately without a clock; after release with the pin low, no rise or fall pulses occur.

Source files
------------

// File: rtl/ext_interrupt_debouncer_multi.sv
// ext_interrupt_debouncer_multi
//   Synchronises and debounces CHANNELS independent external interrupt lines.
//   Each line has its own polarity, assert qualification time and deassert
//   qualification time. The block produces a registered debounced level, one-cycle
//   rise/fall pulses and a sticky pending flag that is cleared by an ack.
//
// Ports
//   i_clk_20mhz   in   1         system clock
//   i_rst_20mhz   in   1         asynchronous active-low reset
//   ei_interrupt  in   CHANNELS  raw interrupt pins, asynchronous to the clock
//   i_ack         in   CHANNELS  clears the matching o_pending bit
//   o_int_deb     out  CHANNELS  debounced, polarity-normalised level (1 = active)
//   o_int_rise    out  CHANNELS  one-cycle pulse on a 0->1 edge of o_int_deb
//   o_int_fall    out  CHANNELS  one-cycle pulse on a 1->0 edge of o_int_deb
//   o_pending     out  CHANNELS  sticky flag: set by a rise, cleared by i_ack
//   o_any_pending out  1         OR of o_pending, cycle-aligned with it
//
// Per-channel FSM (Gray encoded)
//   state    | meaning
//   IDLE     | output inactive, normalised input low
//   QUAL_HI  | output inactive, counting consecutive high samples
//   ASSERTED | output active, normalised input high
//   QUAL_LO  | output active, counting consecutive low samples
module ext_interrupt_debouncer_multi #(
  parameter int                  CHANNELS    = 2,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  T_ASSERT    = 20,
  parameter int                  T_DEASSERT  = 20,
  parameter logic [CHANNELS-1:0] INVERT_MASK = '0
) (
  input  logic                i_clk_20mhz,
  input  logic                i_rst_20mhz,
  input  logic [CHANNELS-1:0] ei_interrupt,
  input  logic [CHANNELS-1:0] i_ack,
  output logic [CHANNELS-1:0] o_int_deb,
  output logic [CHANNELS-1:0] o_int_rise,
  output logic [CHANNELS-1:0] o_int_fall,
  output logic [CHANNELS-1:0] o_pending,
  output logic                o_any_pending
);

  localparam int T_MAX = (T_ASSERT > T_DEASSERT) ? T_ASSERT : T_DEASSERT;
  localparam int TW    = $clog2(T_MAX + 1);

  // The entry sample counts as sample 1 while the timer restarts at 0, so the
  // timer holds (samples seen - 1). The last qualifying sample arrives when the
  // timer already reads T-2.
  localparam logic [TW-1:0] HI_LAST   = TW'((T_ASSERT   >= 2) ? T_ASSERT   - 2 : 0);
  localparam logic [TW-1:0] LO_LAST   = TW'((T_DEASSERT >= 2) ? T_DEASSERT - 2 : 0);
  localparam logic [TW-1:0] TIMER_SAT = {TW{1'b1}};

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_QUAL_HI  = 2'b01;
  localparam logic [1:0] ST_ASSERTED = 2'b11;
  localparam logic [1:0] ST_QUAL_LO  = 2'b10;

  logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
  logic [1:0]             state_q [CHANNELS];
  logic [1:0]             state_d [CHANNELS];
  logic [TW-1:0]          timer_q [CHANNELS];
  logic [TW-1:0]          timer_d [CHANNELS];

  logic [CHANNELS-1:0] norm;
  logic [CHANNELS-1:0] deb_d;
  logic [CHANNELS-1:0] pending_d;

  // Synchronisers reset to the idle pin level so the normalised level is 0
  // and no qualification starts when reset is released.
  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= {SYNC_STAGES{INVERT_MASK[c]}};
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], ei_interrupt[c]};
      end
    end
  end

  always_comb begin
    norm  = '0;
    deb_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      norm[c]    = sync_q[c][SYNC_STAGES-1] ^ INVERT_MASK[c];
      state_d[c] = state_q[c];
      timer_d[c] = timer_q[c];

      case (state_q[c])
        ST_IDLE: begin
          if (norm[c]) begin
            state_d[c] = (T_ASSERT == 1) ? ST_ASSERTED : ST_QUAL_HI;
          end
        end
        ST_QUAL_HI: begin
          if (!norm[c]) begin
            state_d[c] = ST_IDLE;
          end else if (timer_q[c] >= HI_LAST) begin
            state_d[c] = ST_ASSERTED;
          end
        end
        ST_ASSERTED: begin
          if (!norm[c]) begin
            state_d[c] = (T_DEASSERT == 1) ? ST_IDLE : ST_QUAL_LO;
          end
        end
        ST_QUAL_LO: begin
          if (norm[c]) begin
            state_d[c] = ST_ASSERTED;
          end else if (timer_q[c] >= LO_LAST) begin
            state_d[c] = ST_IDLE;
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase

      if (state_d[c] != state_q[c]) begin
        timer_d[c] = '0;
      end else if (((state_q[c] == ST_QUAL_HI) || (state_q[c] == ST_QUAL_LO)) &&
                   (timer_q[c] != TIMER_SAT)) begin
        timer_d[c] = timer_q[c] + TW'(1);
      end

      // With this Gray assignment bit 1 is exactly the debounced level.
      deb_d[c] = state_d[c][1];
    end
  end

  // A rise pulse takes priority over a simultaneous ack.
  assign pending_d = o_int_rise | (o_pending & ~i_ack);

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        timer_q[c] <= '0;
      end
      o_int_deb     <= '0;
      o_int_rise    <= '0;
      o_int_fall    <= '0;
      o_pending     <= '0;
      o_any_pending <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        timer_q[c] <= timer_d[c];
      end
      o_int_deb     <= deb_d;
      o_int_rise    <= deb_d & ~o_int_deb;
      o_int_fall    <= ~deb_d & o_int_deb;
      o_pending     <= pending_d;
      o_any_pending <= |pending_d;
    end
  end

endmodule

// File: tb/tb_ext_interrupt_debouncer_multi.sv
module tb_ext_interrupt_debouncer_multi;

  localparam int         CH  = 2;
  localparam int         SS  = 2;
  localparam int         TA  = 20;
  localparam int         TD  = 20;
  localparam logic [1:0] INV = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] pins;
  logic [CH-1:0] ack;
  logic [CH-1:0] o_int_deb, o_int_rise, o_int_fall, o_pending;
  logic          o_any_pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #25 clk = ~clk;

  ext_interrupt_debouncer_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .T_ASSERT(TA), .T_DEASSERT(TD), .INVERT_MASK(INV)
  ) dut (
    .i_clk_20mhz  (clk),
    .i_rst_20mhz  (rst_n),
    .ei_interrupt (pins),
    .i_ack        (ack),
    .o_int_deb    (o_int_deb),
    .o_int_rise   (o_int_rise),
    .o_int_fall   (o_int_fall),
    .o_pending    (o_pending),
    .o_any_pending(o_any_pending)
  );

  // Reference model: the debounced level flips once the most recent T samples
  // of the (synchroniser-delayed, normalised) pin all disagree with it.
  bit            pipe_q [CH][$];
  bit            hist_q [CH][$];
  logic [CH-1:0] m_deb, m_rise, m_fall, m_pend;
  logic          m_any;

  function automatic void model_reset();
    m_deb = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_any = 1'b0;
    for (int c = 0; c < CH; c++) begin
      pipe_q[c].delete();
      hist_q[c].delete();
      for (int s = 0; s < SS; s++) pipe_q[c].push_back(1'b0);
    end
  endfunction

  function automatic void model_edge();
    logic [CH-1:0] new_pend;
    new_pend = m_rise | (m_pend & ~ack);
    for (int c = 0; c < CH; c++) begin
      bit smp;
      bit flip;
      int t;
      int sz;
      smp = pipe_q[c].pop_front();
      pipe_q[c].push_back(pins[c] ^ INV[c]);
      hist_q[c].push_back(smp);
      if (hist_q[c].size() > 64) void'(hist_q[c].pop_front());
      t    = m_deb[c] ? TD : TA;
      sz   = hist_q[c].size();
      flip = (sz >= t);
      for (int k = sz - t; k < sz && flip; k++) begin
        if (hist_q[c][k] == m_deb[c]) flip = 1'b0;
      end
      m_rise[c] = flip & ~m_deb[c];
      m_fall[c] = flip & m_deb[c];
      if (flip) m_deb[c] = ~m_deb[c];
    end
    m_pend = new_pend;
    m_any  = |new_pend;
  endfunction

  // One clock edge; the model sees the same inputs the DUT sampled, then
  // outputs are observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    pins  = INV;
    ack   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({o_int_deb, o_int_rise, o_int_fall, o_pending, o_any_pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got deb=%b rise=%b fall=%b pend=%b any=%b exp all 0",
               o_int_deb, o_int_rise, o_int_fall, o_pending, o_any_pending);
    end
    #10 rst_n = 1'b1;
    repeat (5) begin
      step();
      n_tests++;
      if ({o_int_deb, o_int_rise, o_int_fall, o_pending} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle got deb=%b rise=%b fall=%b pend=%b exp 0",
                 o_int_deb, o_int_rise, o_int_fall, o_pending);
      end
    end
  endtask

  task automatic test_assert_latency();
    pins = 2'b11;
    for (int e = 1; e <= 22; e++) begin
      logic exp;
      step();
      exp = (e == 22);
      n_tests++;
      if (o_int_deb[0] !== exp) begin
        n_fail++;
        $display("FAIL latency_deb edge=%0d got=%b exp=%b", e, o_int_deb[0], exp);
      end
      n_tests++;
      if (o_int_rise[0] !== exp || o_pending[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_rise edge=%0d got rise=%b pend=%b exp rise=%b pend=0",
                 e, o_int_rise[0], o_pending[0], exp);
      end
    end
    step();
    n_tests++;
    if (o_int_rise[0] !== 1'b0 || o_pending[0] !== 1'b1 || o_any_pending !== 1'b1 ||
        o_int_deb[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_pending got rise=%b pend=%b any=%b deb=%b exp 0 1 1 1",
               o_int_rise[0], o_pending[0], o_any_pending, o_int_deb[0]);
    end
    // release and clear so later tests start idle
    pins = INV;
    repeat (30) step();
    ack = 2'b11;
    step();
    ack = '0;
    n_tests++;
    if (o_int_deb !== 2'b00 || o_pending !== 2'b00) begin
      n_fail++;
      $display("FAIL latency_cleanup got deb=%b pend=%b exp 00 00", o_int_deb, o_pending);
    end
  endtask

  task automatic test_glitch();
    int rises;
    int saw_rise;
    int saw_deb;
    pins[0] = 1'b1;
    repeat (19) step();
    pins[0] = 1'b0;
    rises = 0;
    saw_deb = 0;
    repeat (30) begin
      step();
      if (o_int_deb[0]) saw_deb++;
      if (o_int_rise[0] || o_pending[0]) rises++;
    end
    n_tests++;
    if (saw_deb != 0 || rises != 0 || o_int_deb[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_19 got deb_cycles=%0d rise_or_pend=%0d exp 0 0", saw_deb, rises);
    end
    pins[0] = 1'b1;
    saw_rise = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (o_int_rise[0]) saw_rise++;
    end
    pins[0] = 1'b0;
    repeat (2) begin
      step();
      if (o_int_rise[0]) saw_rise++;
    end
    n_tests++;
    if (saw_rise != 1 || o_int_deb[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_20 got rises=%0d deb=%b exp 1 1", saw_rise, o_int_deb[0]);
    end
    repeat (25) step();
    ack = 2'b01;
    step();
    ack = '0;
  endtask

  task automatic test_deassert_bounce();
    int falls;
    int low_deb;
    pins[0] = 1'b1;
    repeat (25) step();
    n_tests++;
    if (o_int_deb[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_setup got deb=%b exp 1", o_int_deb[0]);
    end
    falls = 0;
    low_deb = 0;
    pins[0] = 1'b0;
    repeat (10) begin step(); if (!o_int_deb[0]) low_deb++; if (o_int_fall[0]) falls++; end
    pins[0] = 1'b1;
    repeat (3) begin step(); if (!o_int_deb[0]) low_deb++; if (o_int_fall[0]) falls++; end
    pins[0] = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      step();
      n_tests++;
      if (o_int_deb[0] !== (e < 22)) begin
        n_fail++;
        $display("FAIL bounce_deb edge=%0d got=%b exp=%b", e, o_int_deb[0], (e < 22));
      end
      if (!o_int_deb[0] && e < 22) low_deb++;
      if (o_int_fall[0]) falls++;
    end
    repeat (5) begin step(); if (o_int_fall[0]) falls++; end
    n_tests++;
    if (falls != 1 || low_deb != 0) begin
      n_fail++;
      $display("FAIL bounce_fall got falls=%0d early_low=%0d exp 1 0", falls, low_deb);
    end
    ack = 2'b01;
    step();
    ack = '0;
  endtask

  task automatic test_polarity();
    n_tests++;
    if (o_int_deb[1] !== 1'b0 || o_int_rise[1] !== 1'b0 || o_pending[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL polarity_idle got deb=%b rise=%b pend=%b exp 0 0 0",
               o_int_deb[1], o_int_rise[1], o_pending[1]);
    end
    pins[1] = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e == 22) begin
        n_tests++;
        if (o_int_deb[1] !== 1'b1 || o_int_rise[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL polarity_assert got deb=%b rise=%b exp 1 1", o_int_deb[1], o_int_rise[1]);
        end
      end
    end
    pins[1] = 1'b1;
    repeat (25) step();
    n_tests++;
    if (o_int_deb[1] !== 1'b0 || o_pending[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL polarity_release got deb=%b pend=%b exp 0 1", o_int_deb[1], o_pending[1]);
    end
    ack = 2'b10;
    step();
    ack = '0;
  endtask

  task automatic test_ack_race();
    pins[0] = 1'b1;
    repeat (22) step();
    n_tests++;
    if (o_int_rise[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL race_rise got rise=%b exp 1", o_int_rise[0]);
    end
    ack = 2'b01;
    step();
    ack = '0;
    n_tests++;
    if (o_pending[0] !== 1'b1 || o_any_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL race_set_wins got pend=%b any=%b exp 1 1", o_pending[0], o_any_pending);
    end
    pins[0] = 1'b0;
    repeat (25) step();
    n_tests++;
    if (o_any_pending !== 1'b1 || o_pending !== 2'b01) begin
      n_fail++;
      $display("FAIL race_hold got pend=%b any=%b exp 01 1", o_pending, o_any_pending);
    end
    ack = 2'b01;
    step();
    ack = '0;
    n_tests++;
    if (o_pending !== 2'b00 || o_any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL race_clear got pend=%b any=%b exp 00 0", o_pending, o_any_pending);
    end
    ack = 2'b11;
    step();
    ack = '0;
    n_tests++;
    if (o_pending !== 2'b00) begin
      n_fail++;
      $display("FAIL race_idle_ack got pend=%b exp 00", o_pending);
    end
  endtask

  task automatic test_random();
    int hold [CH];
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          pins[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(18, 45))
                                                : int'($urandom_range(1, 22));
        end
        hold[c]--;
        ack[c] = ($urandom_range(0, 7) == 0);
      end
      step();
      n_tests++;
      if (o_int_deb !== m_deb || o_int_rise !== m_rise || o_int_fall !== m_fall) begin
        n_fail++;
        $display("FAIL random_level cyc=%0d got deb=%b rise=%b fall=%b exp deb=%b rise=%b fall=%b",
                 cyc, o_int_deb, o_int_rise, o_int_fall, m_deb, m_rise, m_fall);
      end
      n_tests++;
      if (o_pending !== m_pend || o_any_pending !== m_any) begin
        n_fail++;
        $display("FAIL random_pending cyc=%0d got pend=%b any=%b exp pend=%b any=%b",
                 cyc, o_pending, o_any_pending, m_pend, m_any);
      end
    end
    ack  = '0;
    pins = INV;
    repeat (30) step();
  endtask

  task automatic test_async_reset();
    int pulses;
    pins[0] = 1'b1;
    repeat (25) step();
    pins[0] = 1'b0;
    repeat (10) step();
    n_tests++;
    if (o_int_deb[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup got deb=%b exp 1", o_int_deb[0]);
    end
    #10 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_int_deb, o_int_rise, o_int_fall, o_pending, o_any_pending} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got deb=%b rise=%b fall=%b pend=%b any=%b exp all 0",
               o_int_deb, o_int_rise, o_int_fall, o_pending, o_any_pending);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #10 rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      step();
      if (o_int_rise != '0 || o_int_fall != '0 || o_int_deb != '0) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL async_release got active_cycles=%0d exp 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_assert_latency();
    test_glitch();
    test_deassert_bounce();
    test_polarity();
    test_ack_race();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
